// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_write_arbiter
//  Description : Shares the register-file write port between pipeline
//                write-back (always first) and a small debug write FIFO.
//                A watchdog requests a pipeline stall when the FIFO head
//                stays blocked for too long.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_write_arbiter #(
    parameter int LEN      = 32,
    parameter int NB_ADDR  = 5,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4,
    parameter int NB_CNT   = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wb_RegWrite,
    input  logic [NB_ADDR-1:0] i_wb_write_register,
    input  logic [LEN-1:0]     i_wb_write_data,
    input  logic               i_dbg_valid,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    input  logic [LEN-1:0]     i_dbg_data,
    input  logic               i_dbg_flush,
    output logic               o_dbg_ready,
    output logic               o_RegWrite,
    output logic [NB_ADDR-1:0] o_write_register,
    output logic [LEN-1:0]     o_write_data,
    output logic               o_src_dbg,
    output logic               o_stall_req,
    output logic [NB_CNT-1:0]  o_dbg_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    logic [NB_ADDR-1:0] r_mem_addr [DEPTH];
    logic [LEN-1:0]     r_mem_data [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [NB_CNT-1:0]  r_count;
    logic [NB_CNT-1:0]  r_wait_cnt;
    state_t             r_state;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_blocked;
    logic [NB_CNT-1:0]  w_count_next;
    logic [NB_CNT-1:0]  w_wait_next;
    state_t             w_state_next;
    logic [NB_ADDR-1:0] w_head_addr;
    logic [LEN-1:0]     w_head_data;

    assign w_full      = (r_count == NB_CNT'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = i_dbg_valid && !w_full && !i_dbg_flush;
    // The head owns the port whenever the pipeline is idle; it leaves the
    // FIFO at the edge even when addressed to r0 (discarded write).
    assign w_pop       = !i_wb_RegWrite && !w_empty;
    assign w_blocked   = i_wb_RegWrite && !w_empty;
    assign w_head_addr = r_mem_addr[r_rd_ptr];
    assign w_head_data = r_mem_data[r_rd_ptr];

    assign o_dbg_ready = !w_full;
    assign o_dbg_count = r_count;
    assign o_stall_req = (r_state == S_STALL);

    // Occupancy after this edge; push and pop together cancel out.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + NB_CNT'(1);
            2'b01:   w_count_next = r_count - NB_CNT'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage, no reset needed since occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= i_dbg_addr;
            r_mem_data[r_wr_ptr] <= i_dbg_data;
        end
    end

    // FIFO pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_dbg_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
        end
    end

    // Watchdog state and blocked-cycle counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    // Watchdog next state: count blocked cycles, stall at the limit,
    // release once the head finally drains.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                w_wait_next = '0;
                if (w_push) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_pop) begin
                    w_wait_next = '0;
                    if (w_count_next == '0) w_state_next = S_IDLE;
                end else if (w_blocked) begin
                    if (r_wait_cnt == NB_CNT'(MAX_WAIT - 1)) begin
                        w_state_next = S_STALL;
                        w_wait_next  = '0;
                    end else begin
                        w_wait_next = r_wait_cnt + NB_CNT'(1);
                    end
                end
            end
            S_STALL: begin
                w_wait_next = '0;
                if (w_pop) w_state_next = (w_count_next == '0) ? S_IDLE : S_WAIT;
            end
            default: begin
                w_state_next = S_IDLE;
                w_wait_next  = '0;
            end
        endcase
        if (i_dbg_flush) begin
            w_state_next = S_IDLE;
            w_wait_next  = '0;
        end
    end

    // Port mux: pipeline first, then FIFO head; r0 writes are suppressed.
    always_comb begin
        o_src_dbg        = 1'b0;
        o_RegWrite       = 1'b0;
        o_write_register = i_wb_write_register;
        o_write_data     = i_wb_write_data;
        if (i_wb_RegWrite) begin
            o_RegWrite = (i_wb_write_register != '0);
        end else if (!w_empty) begin
            o_src_dbg        = 1'b1;
            o_write_register = w_head_addr;
            o_write_data     = w_head_data;
            o_RegWrite       = (w_head_addr != '0);
        end
    end

endmodule
`default_nettype wire

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
Shares the register-file write port between the pipeline write-back stage and the debug unit, which loads and patches registers. Pipeline write-back always has priority. Debug writes are held in a small FIFO and drained in cycles where the pipeline is not writing. If a debug write is blocked too long, a starvation watchdog requests a pipeline stall. The block sits between the write-back stage output and the register-file write inputs.

Parameters:
LEN, 32, data width of a register write
NB_ADDR, 5, register address width
DEPTH, 2, debug FIFO depth; power of two, at least 2
MAX_WAIT, 4, consecutive blocked cycles before a stall is requested; at least 1
NB_CNT, 3, width of the wait counter and of o_dbg_count; must hold both MAX_WAIT and DEPTH

Ports:
i_clk  in  1  system clock, all state updates on the rising edge
i_rst_n  in  1  asynchronous active-low reset
i_wb_RegWrite  in  1  pipeline write-back write enable
i_wb_write_register  in  NB_ADDR  pipeline destination register
i_wb_write_data  in  LEN  pipeline write data
i_dbg_valid  in  1  debug write request valid
i_dbg_addr  in  NB_ADDR  debug destination register
i_dbg_data  in  LEN  debug write data
i_dbg_flush  in  1  synchronous clear of the debug FIFO and the watchdog
o_dbg_ready  out  1  FIFO can accept a request; equals not-full
o_RegWrite  out  1  register-file write enable
o_write_register  out  NB_ADDR  register-file write address
o_write_data  out  LEN  register-file write data
o_src_dbg  out  1  1 when the current port owner is the debug FIFO
o_stall_req  out  1  request to freeze the pipeline and insert write-back bubbles
o_dbg_count  out  NB_CNT  current FIFO occupancy

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - FIFO empty, read and write pointers 0, wait counter 0, FSM in IDLE.
  - o_dbg_ready=1, o_stall_req=0, o_dbg_count=0.
  - Port outputs follow the pipeline inputs combinationally.
- Debug handshake:
  - An entry is pushed on a rising edge when i_dbg_valid && o_dbg_ready && !i_dbg_flush.
  - There is no bypass: a pushed entry is first eligible for the port in the following cycle.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
- Port arbitration (combinational, every cycle):
  - If i_wb_RegWrite=1: the pipeline owns the port. o_src_dbg=0 and the pipeline address and data are forwarded. The FIFO head is blocked.
  - Else if the FIFO is not empty: the head owns the port, o_src_dbg=1, and the head is popped at the clock edge.
  - Else: o_RegWrite=0, o_src_dbg=0, and address and data forward the pipeline inputs.
- Register zero: any grant with address 0 drives o_RegWrite=0. A debug entry addressed to 0 is still popped, i.e. silently discarded.
- Watchdog FSM:
  - IDLE: FIFO empty. Go to WAIT on the edge after the first push.
  - WAIT: the counter increments on each cycle the head is blocked and clears on each pop.
    - If the head is blocked while counter=MAX_WAIT-1, go to STALL.
    - On a pop that leaves the FIFO empty, go to IDLE.
  - STALL: o_stall_req=1 (registered, asserted from the first STALL cycle). Stay until the head is popped, then go to WAIT (FIFO non-empty) or IDLE, with counter=0.
- Stall contract: while o_stall_req=1, upstream must drive i_wb_RegWrite=0 within 1 cycle. The arbiter does not force a grant.
- Flush: i_dbg_flush=1 at an edge empties the FIFO, clears the counter and moves the FSM to IDLE. Any push attempted in that cycle is dropped. o_dbg_ready returns to 1 in the next cycle.
- Reset mid-operation: reset dominates. All pending debug entries are lost and o_stall_req drops immediately.

Test Plan:
- Reset, then debug push (addr 3, 0xDEADBEEF) with pipeline idle → o_RegWrite=1, addr 3, data 0xDEADBEEF, o_src_dbg=1 exactly one cycle after the push; o_dbg_count returns to 0.
- Pipeline writes r5=0x11 every cycle while 2 debug entries are pushed → o_dbg_ready=0 after the second push; pipeline data is always on the port; o_stall_req=1 after 4 blocked cycles; drop i_wb_RegWrite → entries drain in order in 2 cycles, o_stall_req=0 on the edge after the first pop, FSM back in IDLE.
- Debug write to addr 0 with data 0xFFFF → o_RegWrite=0, entry popped, count 1→0.
- Pipeline write to r0 → o_RegWrite=0, o_src_dbg=0.
- FIFO full, assert i_dbg_flush together with i_dbg_valid → count=0 on the next cycle, no debug write appears on the port, o_dbg_ready=1.
- While in STALL, deassert i_rst_n → o_stall_req=0 and count=0 without a clock edge; normal pass-through after release.
